fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: output buffer entries; only 2 is supported.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port imem_req  out  1  fetch request valid.
REQ-006 SHALL have port imem_addr  out  32  fetch byte address, word-aligned.
REQ-007 SHALL have port imem_gnt  in  1  memory accepts request this cycle.
REQ-008 SHALL have port imem_rvalid  in  1  read data valid.
REQ-009 SHALL have port imem_rdata  in  32  instruction word.
REQ-010 SHALL have port redirect  in  1  control-flow change (jump or taken beq).
REQ-011 SHALL have port redirect_pc  in  32  new fetch address.
REQ-012 SHALL have port inst_valid  out  1  instruction available to the decoder.
REQ-013 SHALL have port inst  out  32  instruction word to the decoder.
REQ-014 SHALL have port inst_pc  out  32  address of inst.
REQ-015 SHALL have port inst_ready  in  1  decoder consumes inst this cycle.

Function
REQ-016 SHALL hold a pc register; imem_addr = pc combinationally.
REQ-017 SHALL use states FETCH (no request outstanding), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded).
REQ-018 SHALL drive imem_req = (state==FETCH) && (FIFO occupancy < 2) && !redirect.
REQ-019 SHALL, on imem_req && imem_gnt, store pc as the outstanding-request address, advance pc by 4 (wrapping 32'hFFFF_FFFC -> 0), and go FETCH->WAIT.
REQ-020 SHALL, in WAIT on imem_rvalid, push {imem_rdata, outstanding-request address} into the FIFO and return to FETCH; room is guaranteed by REQ-018.
REQ-021 SHALL, in DROP on imem_rvalid, discard the data and return to FETCH.
REQ-022 SHALL ignore imem_rvalid in FETCH.
REQ-023 SHALL, on redirect, load pc with {redirect_pc[31:2], 2'b00} and flush every FIFO entry the next cycle.
REQ-024 SHALL on redirect move WAIT->DROP, hold DROP as DROP, and hold FETCH as FETCH.
REQ-025 SHALL, on redirect coinciding with imem_rvalid in WAIT, discard that data and go to FETCH.
REQ-026 SHALL give redirect priority over an inst_ready pop in the same cycle; the flush wins.
REQ-027 SHALL drive inst_valid = FIFO non-empty, with inst and inst_pc from the FIFO head.
REQ-028 SHALL pop the head on inst_valid && inst_ready.
REQ-029 SHALL allow push and pop in the same cycle with occupancy unchanged.
REQ-030 SHALL have a minimum latency of 1 cycle from imem_gnt to imem_rvalid, and 1 cycle from push to inst_valid.
REQ-031 SHALL keep inst and inst_pc stable while inst_valid && !inst_ready.

Reset
REQ-032 SHALL, while rst_n=0, force pc=RESET_PC, state=FETCH, FIFO empty, imem_req=0, inst_valid=0, and inst and inst_pc to 0.
REQ-033 SHALL, on reset asserted mid-transaction, abandon the outstanding request without waiting for imem_rvalid.
REQ-034 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst_n deasserts.

Structure
REQ-035 SHALL place the state enum (FETCH/WAIT/DROP), RESET_PC default and FIFO_DEPTH in shared package fetch_pkg.
REQ-036 SHALL instantiate one sub-module, fetch_fifo: a 2-entry, 64-bit synchronous FIFO with flush, push, pop, full and empty.

Verification
REQ-037 SHALL test reset release with gnt=1 and rvalid one cycle after gnt, ready=1 -> imem_addr 0,4,8; inst_pc 0,4,8 in order, one instruction every 2 cycles.
REQ-038 SHALL test ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req=0, and inst/inst_pc held; on ready=1 they drain in order with pc 0 then 4.
REQ-039 SHALL test redirect to 32'h0000_0103 while WAIT -> the next rvalid data is dropped, FIFO is flushed, the next imem_addr is 32'h0000_0100, and the first post-redirect inst_pc is 32'h0000_0100.
REQ-040 SHALL test redirect in the same cycle as rvalid and inst_ready -> no instruction is delivered and the next fetch is from redirect_pc.
REQ-041 SHALL test RESET_PC=32'hFFFF_FFFC over two fetches -> inst_pc FFFF_FFFC then 0000_0000.
REQ-042 SHALL test rst_n low one cycle after gnt, then a stale rvalid after release -> the stale data is ignored and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its output buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_FIFO_DEPTH = 2;
  localparam int          FIFO_W             = 64;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous buffer holding {instruction, pc} pairs for the decoder.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = FIFO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == 2'd0);
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, redirect handling and a
// two-entry buffer towards the decoder.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [63:0]  fifo_head;

  assign imem_addr  = pc_q;
  assign imem_req   = rst_n && (state_q == FETCH) && !fifo_full && !redirect;
  assign inst_valid = !fifo_empty;
  assign {inst, inst_pc} = fifo_head;
  // The flush on redirect wins over a decoder pop in the same cycle.
  assign fifo_pop   = inst_valid && inst_ready && !redirect;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    fifo_push  = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_req && imem_gnt) begin
          req_addr_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          fifo_push = !redirect;
          state_d   = FETCH;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    if (redirect) begin
      pc_d = word_align(redirect_pc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data ({imem_rdata, req_addr_q}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch, stall, redirect and reset scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic        rst2_n;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        imem_gnt2;
  logic        imem_rvalid2 = 1'b0;
  logic [31:0] imem_rdata2  = 32'h0;
  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic        inst_valid2;
  logic [31:0] inst2;
  logic [31:0] inst_pc2;
  logic        inst_ready2;

  logic        auto_mem;
  logic        frc_rvalid;
  logic [31:0] frc_rdata;

  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk         (clk),
    .rst_n       (rst2_n),
    .imem_req    (imem_req2),
    .imem_addr   (imem_addr2),
    .imem_gnt    (imem_gnt2),
    .imem_rvalid (imem_rvalid2),
    .imem_rdata  (imem_rdata2),
    .redirect    (redirect2),
    .redirect_pc (redirect_pc2),
    .inst_valid  (inst_valid2),
    .inst        (inst2),
    .inst_pc     (inst_pc2),
    .inst_ready  (inst_ready2)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of falling edges waited until a granted request is seen.
  task automatic wait_grant(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_req && imem_gnt) && n < 40);
    if (!(imem_req && imem_gnt)) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within %0d cycles", name, n);
    end
  endtask

  // Memory model: answers a granted request one cycle later unless forced.
  logic        fire_s;
  logic [31:0] addr_s;
  always begin
    @(negedge clk);
    fire_s = imem_req && imem_gnt;
    addr_s = imem_addr;
    @(posedge clk);
    #2;
    if (auto_mem) begin
      imem_rvalid = fire_s;
      imem_rdata  = data_of(addr_s);
    end else begin
      imem_rvalid = frc_rvalid;
      imem_rdata  = frc_rdata;
    end
  end

  logic        fire2_s;
  logic [31:0] addr2_s;
  always begin
    @(negedge clk);
    fire2_s = imem_req2 && imem_gnt2;
    addr2_s = imem_addr2;
    @(posedge clk);
    #2;
    imem_rvalid2 = fire2_s;
    imem_rdata2  = data_of(addr2_s);
  end

  // Scoreboard monitor: every delivered instruction must match the queue head.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected nothing", inst_pc, inst);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("deliver_pc", inst_pc, e[31:0]);
        check("deliver_inst", inst, e[63:32]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    imem_gnt     = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    inst_ready   = 1'b1;
    auto_mem     = 1'b1;
    frc_rvalid   = 1'b0;
    frc_rdata    = 32'h0;
    rst2_n       = 1'b0;
    imem_gnt2    = 1'b1;
    redirect2    = 1'b0;
    redirect_pc2 = 32'h0;
    inst_ready2  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst2_req", imem_req2, 0);

    // Streaming fetch: 0, 4, 8 one instruction every two cycles
    tick();
    exp_q.push_back({data_of(32'h0), 32'h0});
    exp_q.push_back({data_of(32'h4), 32'h4});
    exp_q.push_back({data_of(32'h8), 32'h8});
    imem_gnt = 1'b1;
    rst_n    = 1'b1;
    wait_grant("t1_g0", n);
    check("t1_first_cycle", n, 1);
    check("t1_addr0", imem_addr, 32'h0);
    wait_grant("t1_g1", n);
    check("t1_gap1", n, 2);
    check("t1_addr1", imem_addr, 32'h4);
    wait_grant("t1_g2", n);
    check("t1_gap2", n, 2);
    check("t1_addr2", imem_addr, 32'h8);
    tick();
    imem_gnt = 1'b0;
    repeat (5) tick();
    check("t1_drained", exp_q.size(), 0);

    // Decoder stall: buffer fills with two entries and holds the head
    rst_n      = 1'b0;
    inst_ready = 1'b0;
    tick();
    rst_n    = 1'b1;
    imem_gnt = 1'b1;
    exp_q.push_back({data_of(32'h0), 32'h0});
    exp_q.push_back({data_of(32'h4), 32'h4});
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_req_off", imem_req, 0);
      check("t2_valid", inst_valid, 1);
      check("t2_hold_pc", inst_pc, 32'h0);
      check("t2_hold_inst", inst, data_of(32'h0));
      tick();
    end
    imem_gnt   = 1'b0;
    inst_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("t2_empty", inst_valid, 0);
    check("t2_drained", exp_q.size(), 0);

    // Redirect while waiting: late response dropped, buffer flushed
    tick();
    inst_ready = 1'b0;
    imem_gnt   = 1'b1;
    wait_grant("t3_g0", n);
    check("t3_addr0", imem_addr, 32'h8);
    tick();
    tick();
    @(negedge clk);
    check("t3_req1", imem_req, 1);
    check("t3_addr1", imem_addr, 32'hC);
    auto_mem   = 1'b0;
    frc_rvalid = 1'b0;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check("t3_req_wait", imem_req, 0);
    check("t3_buffered", inst_valid, 1);
    tick();
    redirect   = 1'b0;
    frc_rvalid = 1'b1;
    frc_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    check("t3_flushed", inst_valid, 0);
    check("t3_req_drop", imem_req, 0);
    tick();
    frc_rvalid = 1'b0;
    auto_mem   = 1'b1;
    @(negedge clk);
    check("t3_req_new", imem_req, 1);
    check("t3_addr_new", imem_addr, 32'h0000_0100);
    check("t3_no_stale", inst_valid, 0);
    exp_q.push_back({data_of(32'h100), 32'h100});
    tick();
    imem_gnt   = 1'b0;
    inst_ready = 1'b1;
    repeat (4) tick();
    check("t3_drained", exp_q.size(), 0);

    // Redirect coinciding with rvalid and inst_ready
    inst_ready = 1'b0;
    imem_gnt   = 1'b1;
    wait_grant("t4_g0", n);
    check("t4_addr0", imem_addr, 32'h104);
    tick();
    tick();
    @(negedge clk);
    check("t4_addr1", imem_addr, 32'h108);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    inst_ready  = 1'b1;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("t4_flushed", inst_valid, 0);
    check("t4_req", imem_req, 1);
    check("t4_addr_new", imem_addr, 32'h200);
    exp_q.push_back({data_of(32'h200), 32'h200});
    tick();
    imem_gnt = 1'b0;
    repeat (4) tick();
    check("t4_drained", exp_q.size(), 0);

    // Reset mid-transaction, stale response after release
    auto_mem   = 1'b0;
    frc_rvalid = 1'b0;
    imem_gnt   = 1'b1;
    wait_grant("t5_g0", n);
    check("t5_addr0", imem_addr, 32'h204);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_req", imem_req, 0);
    check("t5_rst_valid", inst_valid, 0);
    tick();
    rst_n      = 1'b1;
    frc_rvalid = 1'b1;
    frc_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t5_req_release", imem_req, 1);
    check("t5_addr_release", imem_addr, 32'h0);
    exp_q.push_back({data_of(32'h0), 32'h0});
    tick();
    frc_rvalid = 1'b0;
    auto_mem   = 1'b1;
    imem_gnt   = 1'b0;
    repeat (4) tick();
    check("t5_drained", exp_q.size(), 0);

    // Reset PC at the top of the address space wraps to zero
    rst2_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!inst_valid2 && n < 40);
      check("t6_valid", inst_valid2, 1);
      check("t6_pc", inst_pc2, (k == 0) ? 32'hFFFF_FFFC : 32'h0);
      check("t6_inst", inst2, (k == 0) ? data_of(32'hFFFF_FFFC) : data_of(32'h0));
    end

    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
